// File: rtl/pacman_pkg.sv
// Shared Pac-Man constants: game state and item codes, score values,
// the eat scheduler state enum and two small helpers.
package pacman_pkg;

    localparam logic [3:0]  GS_PLAY      = 4'd2;

    localparam logic [1:0]  I_NONE       = 2'd0;
    localparam logic [1:0]  I_DOT        = 2'd1;
    localparam logic [1:0]  I_ENERGIZER  = 2'd2;

    localparam logic [11:0] SC_DOT       = 12'd10;
    localparam logic [11:0] SC_ENERGIZER = 12'd50;
    localparam logic [11:0] SC_GHOST     = 12'd200;

    // Ghost combo index saturates here: 200 << 3 = 1600 points.
    localparam logic [1:0]  COMBO_MAX    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ITEM   = 3'd1,
        ST_GHOST  = 3'd2,
        ST_FREEZE = 3'd3,
        ST_DEATH  = 3'd4
    } eat_state_e;

    // Points awarded for an eaten map item; unknown codes score nothing.
    function automatic logic [11:0] item_score(input logic [1:0] t);
        case (t)
            I_DOT:       return SC_DOT;
            I_ENERGIZER: return SC_ENERGIZER;
            default:     return 12'd0;
        endcase
    endfunction

    // Isolates the lowest set bit of a ghost mask (blinky has priority).
    function automatic logic [3:0] lowest_bit(input logic [3:0] m);
        return m & (~m + 4'd1);
    endfunction

endpackage

// File: rtl/fright_timer.sv
// Loadable down-counter: clear beats load, load beats counting, and the
// count holds while paused. o_expire flags the cycle in which the count
// steps from 1 to 0.
module fright_timer #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_pause,
    output logic [W-1:0] o_count,
    output logic         o_expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, reload, or one step down unless paused or empty.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = i_load_val;
        end else if (!i_pause && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count  = cnt_q;
    assign o_expire = (cnt_q == W'(1)) && !i_pause;

endmodule

// File: rtl/eat_event_sched.sv
// Eat event scheduler: turns item hits, ghost bites and pacman deaths into
// map-clear requests, score increments, fright/freeze modes and level-clear.
// Build option: define EAT_FREEZE_EN to pause the game for FREEZE_CYCLES
// after each ghost is eaten; without it ghosts are serviced one per cycle.
// All outputs are decoded from registers only.
// Handshake: every *_valid / pulse output is a one-cycle strobe with no
// ready; the consumer must take it in the cycle it is high.
module eat_event_sched
    import pacman_pkg::*;
#(
    parameter logic [23:0] FRIGHT_CYCLES = 24'd6000000,
    parameter logic [23:0] FREEZE_CYCLES = 24'd600000,
    parameter logic [7:0]  DOT_TOTAL     = 8'd244
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_game_state,
    input  logic        i_item_eaten,
    input  logic [1:0]  i_item_type,
    input  logic [5:0]  i_item_x,
    input  logic [5:0]  i_item_y,
    input  logic [3:0]  i_ghost_eaten,
    input  logic        i_pacman_eaten,
    output logic        o_clr_valid,
    output logic [5:0]  o_clr_x,
    output logic [5:0]  o_clr_y,
    output logic        o_score_valid,
    output logic [11:0] o_score_add,
    output logic        o_fright,
    output logic        o_freeze,
    output logic [3:0]  o_ghost_ret,
    output logic        o_death,
    output logic        o_level_clear,
    output logic [7:0]  o_dots_left,
    output logic [2:0]  o_dbg_state
);

    eat_state_e  state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [1:0]  combo_q, combo_d;
    logic [5:0]  item_x_q, item_x_d;
    logic [5:0]  item_y_q, item_y_d;
    logic [1:0]  item_type_q, item_type_d;
    logic [5:0]  last_x_q, last_x_d;
    logic [5:0]  last_y_q, last_y_d;
    logic        released_q, released_d;
    logic [7:0]  dots_q, dots_d;
    logic        lc_arm_q, lc_arm_d;
    logic        level_clear_q, level_clear_d;

    logic        play;
    logic        item_ok;
    logic [3:0]  ghost_sel;
    logic        fright_load;
    logic        fright_clear;
    logic [23:0] fright_count;
    logic        fright_expire;

    assign play      = (i_game_state == GS_PLAY);
    assign ghost_sel = lowest_bit(pending_q);

    // A held hit on the tile just cleared is a stale map read, unless the
    // eaten flag dropped in between.
    assign item_ok = i_item_eaten && (i_item_type != I_NONE) &&
                     (({i_item_x, i_item_y} != {last_x_q, last_y_q}) || released_q);

`ifdef EAT_FREEZE_EN
    logic        freeze_load;
    logic [23:0] freeze_count;
    logic        freeze_expire;

    assign o_freeze = (state_q == ST_FREEZE);

    fright_timer #(.W(24)) u_freeze_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (~play),
        .i_load     (freeze_load),
        .i_load_val (FREEZE_CYCLES),
        .i_pause    (1'b0),
        .o_count    (freeze_count),
        .o_expire   (freeze_expire)
    );
`else
    logic unused_freeze_cycles;
    assign unused_freeze_cycles = ^FREEZE_CYCLES;
    assign o_freeze = 1'b0;
`endif

    fright_timer #(.W(24)) u_fright_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (fright_clear),
        .i_load     (fright_load),
        .i_load_val (FRIGHT_CYCLES),
        .i_pause    (o_freeze),
        .o_count    (fright_count),
        .o_expire   (fright_expire)
    );

    // Next-state and bookkeeping for the scheduler FSM.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        combo_d       = combo_q;
        item_x_d      = item_x_q;
        item_y_d      = item_y_q;
        item_type_d   = item_type_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        released_d    = released_q | ~i_item_eaten;
        dots_d        = dots_q;
        lc_arm_d      = 1'b0;
        level_clear_d = lc_arm_q;
        fright_load   = 1'b0;
        fright_clear  = 1'b0;
`ifdef EAT_FREEZE_EN
        freeze_load   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (play) begin
                    if (i_pacman_eaten) begin
                        // Fright ends as the death starts, not a cycle later.
                        state_d      = ST_DEATH;
                        fright_clear = 1'b1;
                        combo_d      = 2'd0;
                        pending_d    = 4'd0;
                    end else if (i_ghost_eaten != 4'd0) begin
                        state_d   = ST_GHOST;
                        pending_d = pending_q | i_ghost_eaten;
                    end else if (item_ok) begin
                        state_d     = ST_ITEM;
                        item_x_d    = i_item_x;
                        item_y_d    = i_item_y;
                        item_type_d = i_item_type;
                    end
                end
            end
            ST_ITEM: begin
                last_x_d   = item_x_q;
                last_y_d   = item_y_q;
                released_d = 1'b0;
                if (dots_q != 8'd0) begin
                    dots_d = dots_q - 8'd1;
                end
                lc_arm_d = (dots_q == 8'd1);
                if (item_type_q == I_ENERGIZER) begin
                    fright_load = 1'b1;
                    combo_d     = 2'd0;
                end
                state_d = ST_IDLE;
            end
            ST_GHOST: begin
                pending_d = (pending_q & ~ghost_sel) | i_ghost_eaten;
                if (ghost_sel != 4'd0 && combo_q != COMBO_MAX) begin
                    combo_d = combo_q + 2'd1;
                end
`ifdef EAT_FREEZE_EN
                if (ghost_sel != 4'd0) begin
                    state_d     = ST_FREEZE;
                    freeze_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = (pending_d != 4'd0) ? ST_GHOST : ST_IDLE;
`endif
            end
`ifdef EAT_FREEZE_EN
            ST_FREEZE: begin
                pending_d = pending_q | i_ghost_eaten;
                if (freeze_expire || freeze_count == 24'd0) begin
                    state_d = (pending_d != 4'd0) ? ST_GHOST : ST_IDLE;
                end
            end
`endif
            ST_DEATH: begin
                fright_clear = 1'b1;
                combo_d      = 2'd0;
                pending_d    = 4'd0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Fright running out ends the ghost combo.
        if (fright_expire) begin
            combo_d = 2'd0;
        end

        // Outside play everything transient is dropped; the dot count holds.
        if (!play) begin
            state_d      = ST_IDLE;
            pending_d    = 4'd0;
            combo_d      = 2'd0;
            fright_clear = 1'b1;
            fright_load  = 1'b0;
            dots_d       = dots_q;
            lc_arm_d     = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= 4'd0;
            combo_q       <= 2'd0;
            item_x_q      <= 6'd0;
            item_y_q      <= 6'd0;
            item_type_q   <= I_NONE;
            last_x_q      <= 6'd0;
            last_y_q      <= 6'd0;
            released_q    <= 1'b1;
            dots_q        <= DOT_TOTAL;
            lc_arm_q      <= 1'b0;
            level_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            combo_q       <= combo_d;
            item_x_q      <= item_x_d;
            item_y_q      <= item_y_d;
            item_type_q   <= item_type_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            released_q    <= released_d;
            dots_q        <= dots_d;
            lc_arm_q      <= lc_arm_d;
            level_clear_q <= level_clear_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        o_clr_valid   = (state_q == ST_ITEM);
        o_score_valid = 1'b0;
        o_score_add   = 12'd0;
        o_ghost_ret   = 4'd0;
        if (state_q == ST_ITEM) begin
            o_score_valid = 1'b1;
            o_score_add   = item_score(item_type_q);
        end else if (state_q == ST_GHOST && ghost_sel != 4'd0) begin
            o_score_valid = 1'b1;
            o_score_add   = SC_GHOST << combo_q;
            o_ghost_ret   = ghost_sel;
        end
    end

    assign o_clr_x       = item_x_q;
    assign o_clr_y       = item_y_q;
    assign o_fright      = (fright_count != 24'd0);
    assign o_death       = (state_q == ST_DEATH);
    assign o_level_clear = level_clear_q;
    assign o_dots_left   = dots_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_eat_event_sched.sv
// Directed bench for eat_event_sched with a score/clear/ghost scoreboard.
module tb_eat_event_sched;
    import pacman_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  game_state;
    logic        item_eaten;
    logic [1:0]  item_type;
    logic [5:0]  item_x;
    logic [5:0]  item_y;
    logic [3:0]  ghost_eaten;
    logic        pacman_eaten;
    logic        o_clr_valid;
    logic [5:0]  o_clr_x;
    logic [5:0]  o_clr_y;
    logic        o_score_valid;
    logic [11:0] o_score_add;
    logic        o_fright;
    logic        o_freeze;
    logic [3:0]  o_ghost_ret;
    logic        o_death;
    logic        o_level_clear;
    logic [7:0]  o_dots_left;
    logic [2:0]  o_dbg_state;

    logic [11:0] score_q[$];
    logic [11:0] clr_q[$];
    logic [3:0]  ghost_q[$];

    int total = 0;
    int bad   = 0;
    int exp_dots = 244;

    eat_event_sched #(
        .FRIGHT_CYCLES (24'd60),
        .FREEZE_CYCLES (24'd4),
        .DOT_TOTAL     (8'd244)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_game_state   (game_state),
        .i_item_eaten   (item_eaten),
        .i_item_type    (item_type),
        .i_item_x       (item_x),
        .i_item_y       (item_y),
        .i_ghost_eaten  (ghost_eaten),
        .i_pacman_eaten (pacman_eaten),
        .o_clr_valid    (o_clr_valid),
        .o_clr_x        (o_clr_x),
        .o_clr_y        (o_clr_y),
        .o_score_valid  (o_score_valid),
        .o_score_add    (o_score_add),
        .o_fright       (o_fright),
        .o_freeze       (o_freeze),
        .o_ghost_ret    (o_ghost_ret),
        .o_death        (o_death),
        .o_level_clear  (o_level_clear),
        .o_dots_left    (o_dots_left),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (o_dbg_state == 3'(ST_IDLE)) break;
            tick();
        end
        chk("wait_idle", o_dbg_state, ST_IDLE);
    endtask

    task automatic eat_item(input logic [5:0] x, input logic [5:0] y,
                            input logic [1:0] t, input int hold);
        clr_q.push_back({x, y});
        score_q.push_back((t == I_ENERGIZER) ? 12'd50 : 12'd10);
        item_eaten = 1'b1;
        item_type  = t;
        item_x     = x;
        item_y     = y;
        repeat (hold) tick();
        item_eaten = 1'b0;
        item_type  = I_NONE;
        tick();
        tick();
        if (exp_dots != 0) exp_dots--;
        chk("dots_left", o_dots_left, exp_dots);
    endtask

    task automatic ghost_hit(input logic [3:0] g);
        ghost_eaten = g;
        tick();
        ghost_eaten = 4'd0;
    endtask

    // Scoreboard: every strobe must match the head of its expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_score_valid) begin
                chk("score_expected", score_q.size() != 0, 1);
                if (score_q.size() != 0) chk("score_add", o_score_add, score_q.pop_front());
            end
            if (o_clr_valid) begin
                chk("clr_expected", clr_q.size() != 0, 1);
                if (clr_q.size() != 0) chk("clr_xy", {o_clr_x, o_clr_y}, clr_q.pop_front());
            end
            if (o_ghost_ret != 4'd0) begin
                chk("ghost_expected", ghost_q.size() != 0, 1);
                if (ghost_q.size() != 0) chk("ghost_ret", o_ghost_ret, ghost_q.pop_front());
            end
        end
    end

    initial begin
        int n_hi;
        int lc_cnt;
        int k;
        logic exp_frz;
`ifdef EAT_FREEZE_EN
        exp_frz = 1'b1;
`else
        exp_frz = 1'b0;
`endif
        rst          = 1'b1;
        game_state   = GS_PLAY;
        item_eaten   = 1'b0;
        item_type    = I_NONE;
        item_x       = 6'd0;
        item_y       = 6'd0;
        ghost_eaten  = 4'd0;
        pacman_eaten = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_dots", o_dots_left, 244);
        chk("rst_fright", o_fright, 0);
        chk("rst_freeze", o_freeze, 0);
        chk("rst_score_valid", o_score_valid, 0);
        chk("rst_clr_valid", o_clr_valid, 0);
        chk("rst_death", o_death, 0);
        chk("rst_state", o_dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();

        // Dot held 5 cycles: one clear, one score, one decrement.
        eat_item(6'd3, 6'd4, I_DOT, 5);
        chk("dot_no_fright", o_fright, 0);

        // Energizer, then two ghosts in one event.
        eat_item(6'd5, 6'd5, I_ENERGIZER, 1);
        chk("fright_on", o_fright, 1);
        ghost_q.push_back(4'b0001); score_q.push_back(12'd200);
        ghost_q.push_back(4'b0100); score_q.push_back(12'd400);
        ghost_hit(4'b0101);
        tick();
        chk("freeze_after_ghost", o_freeze, exp_frz);
        wait_idle(100);

        // Fresh energizer resets combo; four ghosts plus a fifth saturates.
        eat_item(6'd6, 6'd6, I_ENERGIZER, 1);
        ghost_q.push_back(4'b0001); score_q.push_back(12'd200);
        ghost_q.push_back(4'b0010); score_q.push_back(12'd400);
        ghost_q.push_back(4'b0100); score_q.push_back(12'd800);
        ghost_q.push_back(4'b1000); score_q.push_back(12'd1600);
        ghost_hit(4'b1111);
        wait_idle(100);
        ghost_q.push_back(4'b0001); score_q.push_back(12'd1600);
        ghost_hit(4'b0001);
        wait_idle(100);
        chk("fright_before_death", o_fright, 1);

        // Death wins over a simultaneous ghost bite.
        pacman_eaten = 1'b1;
        ghost_eaten  = 4'b0010;
        tick();
        pacman_eaten = 1'b0;
        ghost_eaten  = 4'd0;
        chk("death_pulse", o_death, 1);
        chk("death_fright", o_fright, 0);
        chk("death_no_ghost", o_ghost_ret, 0);
        tick();
        chk("death_once", o_death, 0);
        chk("death_fright_after", o_fright, 0);
        chk("death_state", o_dbg_state, ST_IDLE);

        // Second energizer half way through fright reloads it and the combo.
        eat_item(6'd7, 6'd7, I_ENERGIZER, 1);
        ghost_q.push_back(4'b0001); score_q.push_back(12'd200);
        ghost_hit(4'b0001);
        wait_idle(100);
        repeat (20) tick();
        chk("fright_mid", o_fright, 1);
        clr_q.push_back({6'd8, 6'd8}); score_q.push_back(12'd50);
        ghost_q.push_back(4'b0001); score_q.push_back(12'd200);
        item_eaten = 1'b1; item_type = I_ENERGIZER; item_x = 6'd8; item_y = 6'd8;
        tick();
        item_eaten = 1'b0; item_type = I_NONE;
        exp_dots--;
        n_hi = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_fright) n_hi++;
            if (i == 0) ghost_eaten = 4'b0001;
            if (i == 1) ghost_eaten = 4'd0;
        end
        chk("fright_hold", n_hi, 60);
        for (int i = 0; i < 40; i++) begin
            if (!o_fright) break;
            tick();
        end
        chk("fright_expire", o_fright, 0);
        chk("dots_after_reload", o_dots_left, exp_dots);

        // Leaving play drops fright and ignores items.
        eat_item(6'd9, 6'd9, I_ENERGIZER, 1);
        chk("fright_on_2", o_fright, 1);
        game_state = 4'd0;
        tick();
        chk("fright_nonplay", o_fright, 0);
        item_eaten = 1'b1; item_type = I_DOT; item_x = 6'd10; item_y = 6'd10;
        tick();
        tick();
        chk("dots_hold", o_dots_left, exp_dots);
        chk("nonplay_state", o_dbg_state, ST_IDLE);
        item_eaten = 1'b0; item_type = I_NONE;
        game_state = GS_PLAY;
        tick();

        // Eat down to the last dot with mixed item types.
        k = 0;
        while (exp_dots > 1) begin
            eat_item(k[5:0], 6'd20 + 6'(k >> 6),
                     ($urandom_range(0, 1) == 0) ? I_DOT : I_ENERGIZER, 1);
            k++;
        end

        // Last dot: count hits 0, level clear pulses exactly once.
        clr_q.push_back({6'd63, 6'd63}); score_q.push_back(12'd10);
        item_eaten = 1'b1; item_type = I_DOT; item_x = 6'd63; item_y = 6'd63;
        tick();
        item_eaten = 1'b0; item_type = I_NONE;
        exp_dots = 0;
        lc_cnt = 0;
        tick();
        chk("dots_zero", o_dots_left, 0);
        if (o_level_clear) lc_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_level_clear) lc_cnt++;
        end
        chk("level_clear_once", lc_cnt, 1);
        eat_item(6'd62, 6'd62, I_DOT, 1);
        chk("dots_saturate", o_dots_left, 0);

`ifdef EAT_FREEZE_EN
        // Reset in the middle of a freeze.
        eat_item(6'd1, 6'd2, I_ENERGIZER, 1);
        ghost_q.push_back(4'b0100); score_q.push_back(12'd200);
        ghost_hit(4'b0100);
        tick();
        chk("freeze_before_rst", o_freeze, 1);
        rst = 1'b1;
        tick();
`else
        // Reset in the middle of an item cycle.
        item_eaten = 1'b1; item_type = I_DOT; item_x = 6'd1; item_y = 6'd2;
        tick();
        rst = 1'b1;
        tick();
        item_eaten = 1'b0; item_type = I_NONE;
`endif
        chk("rst2_freeze", o_freeze, 0);
        chk("rst2_fright", o_fright, 0);
        chk("rst2_dots", o_dots_left, 244);
        chk("rst2_score_valid", o_score_valid, 0);
        chk("rst2_clr_valid", o_clr_valid, 0);
        chk("rst2_ghost_ret", o_ghost_ret, 0);
        chk("rst2_level_clear", o_level_clear, 0);
        chk("rst2_state", o_dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();
        tick();

        chk("score_q_empty", score_q.size(), 0);
        chk("clr_q_empty", clr_q.size(), 0);
        chk("ghost_q_empty", ghost_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eat_event_sched.md
EAT_EVENT_SCHED -- requirements
Module: eat_event_sched

Interface
REQ-001 SHALL have parameter FRIGHT_CYCLES, default 24'd6000000, meaning frightened-mode duration in clocks.
REQ-002 SHALL have parameter FREEZE_CYCLES, default 24'd600000, meaning game-freeze length after each ghost eaten.
REQ-003 SHALL have parameter DOT_TOTAL, default 8'd244, meaning dots plus energizers per level.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_game_state, input, 4 bits: global game state.
REQ-007 SHALL have ports i_item_eaten (1), i_item_type (2), i_item_x (6) and i_item_y (6), all inputs: level-held item hit at pacman tile.
REQ-008 SHALL have port i_ghost_eaten, input, 4 bits: {clyde,inky,pinky,blinky} collision while frightened.
REQ-009 SHALL have port i_pacman_eaten, input, 1 bit: lethal ghost collision.
REQ-010 SHALL have ports o_clr_valid (1), o_clr_x (6) and o_clr_y (6), all outputs: one-cycle item-map clear request.
REQ-011 SHALL have ports o_score_valid (1) and o_score_add (12), both outputs: one-cycle score increment.
REQ-012 SHALL have outputs o_fright (1), o_freeze (1), o_ghost_ret (4, one-hot pulse), o_death (1, pulse), o_level_clear (1, pulse) and o_dots_left (8).

Function
REQ-013 SHALL run an FSM with states IDLE, ITEM, GHOST, FREEZE and DEATH.
REQ-014 SHALL, in IDLE with i_game_state==GS_PLAY, select by priority: i_pacman_eaten -> DEATH; any i_ghost_eaten -> GHOST; qualified item -> ITEM.
REQ-015 SHALL, in DEATH, pulse o_death for one cycle, clear o_fright, reset the combo and pending mask, then return to IDLE.
REQ-016 SHALL, on GHOST entry, latch i_ghost_eaten into the pending mask, OR-ing in any new bits while GHOST or FREEZE is active.
REQ-017 SHALL, per GHOST cycle, service the lowest-index pending ghost: pulse its o_ghost_ret bit, set o_score_add=200<<combo with o_score_valid=1, increment combo saturating at 3 (1600 max), clear its pending bit, then go to FREEZE.
REQ-018 SHALL, in FREEZE, hold o_freeze=1 for FREEZE_CYCLES clocks, then go to GHOST if the pending mask is nonzero, else to IDLE.
REQ-019 SHALL, in ITEM (one cycle), assert o_clr_valid with the latched x/y and o_score_valid with 10 (I_DOT) or 50 (I_ENERGIZER), decrement o_dots_left, then return to IDLE.
REQ-020 SHALL treat an item as qualified only if i_item_type is not I_NONE and its (x,y) differs from the last cleared tile, or i_item_eaten has deasserted since that clear; this suppresses duplicates caused by map-update latency.
REQ-021 SHALL, on an energizer, reload the fright counter to FRIGHT_CYCLES, set o_fright and reset combo to 0, including when already frightened.
REQ-022 SHALL decrement the fright counter every cycle that o_freeze=0; on reaching 0 it SHALL clear o_fright and reset combo.
REQ-023 SHALL pulse o_level_clear in the cycle after o_dots_left becomes 0; o_dots_left SHALL saturate at 0.
REQ-024 SHALL, when i_game_state!=GS_PLAY, force the FSM to IDLE, clear the pending mask, o_freeze and o_fright, and hold o_dots_left.
REQ-025 SHALL drive every pulse output for exactly one cycle, with no output combinationally dependent on inputs.

Reset
REQ-026 SHALL, on i_rst, set the FSM to IDLE, all outputs to 0 except o_dots_left=DOT_TOTAL, and the fright counter, freeze counter, combo, pending mask and last-cleared tile to 0.
REQ-027 SHALL let i_rst asserted mid-FREEZE or mid-ITEM take effect on the next edge, emitting no pulses.

Configuration
REQ-028 SHALL, with EAT_FREEZE_EN defined, implement the FREEZE state as specified.
REQ-029 SHALL, without EAT_FREEZE_EN, omit FREEZE: GHOST loops on itself while the mask is nonzero, one ghost per cycle, o_freeze tied to 0 and no freeze counter instantiated.

Structure
REQ-030 SHALL take GS_PLAY, I_NONE, I_DOT, I_ENERGIZER, score constants (10/50/200) and the FSM state enum from the shared pacman_pkg package.
REQ-031 SHALL instantiate one sub-module, fright_timer (load, pause, count, expire pulse), used for the fright counter and, under EAT_FREEZE_EN, the freeze counter.

Verification
REQ-032 SHALL check: dot held 5 cycles at (3,4) -> exactly one o_clr_valid (3,4), score 10, o_dots_left 244->243.
REQ-033 SHALL check: energizer, then i_ghost_eaten=4'b0101 -> o_ghost_ret 0001 score 200, freeze, then 0100 score 400.
REQ-034 SHALL check: four ghosts eaten in one frightened period, then a fifth event -> scores 200, 400, 800, 1600, 1600.
REQ-035 SHALL check: i_pacman_eaten and i_ghost_eaten asserted in the same cycle -> o_death only, o_fright=0.
REQ-036 SHALL check: second energizer at half FRIGHT_CYCLES -> counter reloaded, combo 0, o_fright stays 1 the full reload period.
REQ-037 SHALL check: last dot eaten -> o_dots_left=0, o_level_clear pulses once; i_rst mid-FREEZE -> all outputs reset next cycle.
